// File: rtl/clk_pulse_multi.sv
// Multi-channel programmable pulse generator: one shared prescaled period counter,
// per-channel start/end windows. Optional per-channel polarity via CLK_PULSE_MULTI_INVERT_EN.
//
// state | meaning
// IDLE  | disabled, counters held at 0, pulses low
// ARMED | one-shot waiting for trig, counters held at 0
// RUN   | prescaler and period counter advancing, windows compared
module clk_pulse_multi #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 8,
  parameter int DIV_WIDTH   = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   trig,
  input  logic [COUNT_WIDTH-1:0] period,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [COUNT_WIDTH-1:0] cfg_start,
  input  logic [COUNT_WIDTH-1:0] cfg_end,
  input  logic                   cfg_invert,
  output logic [CHANNELS-1:0]    pulse,
  output logic                   busy,
  output logic                   cycle_done
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0]   pre_q, pre_d;
  logic [COUNT_WIDTH-1:0] start_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] start_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] end_q   [CHANNELS];
  logic [COUNT_WIDTH-1:0] end_d   [CHANNELS];
  logic [CHANNELS-1:0]    pulse_q, pulse_d;
  logic                   done_q, done_d;
  logic [CHANNELS-1:0]    win;
  logic [CHANNELS-1:0]    pol;

`ifdef CLK_PULSE_MULTI_INVERT_EN
  logic [CHANNELS-1:0]    inv_q, inv_d;

  always_comb begin
    inv_d = inv_q;
    if (cfg_we && (int'(cfg_ch) < CHANNELS)) inv_d[cfg_ch] = cfg_invert;
  end

  always_ff @(posedge clk) begin
    if (rst) inv_q <= '0;
    else     inv_q <= inv_d;
  end

  assign pol = inv_q;
`else
  logic unused_cfg_invert;
  assign unused_cfg_invert = cfg_invert;
  assign pol = '0;
`endif

  // Window compare uses the registered count, so pulse trails count by one clock.
  always_comb begin
    win = '0;
    for (int i = 0; i < CHANNELS; i++)
      win[i] = (start_q[i] <= count_q) && (count_q < end_q[i]);
  end

  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
      start_d[cfg_ch] = cfg_start;
      end_d[cfg_ch]   = cfg_end;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    pulse_d = '0;
    done_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      count_d = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = mode ? ARMED : RUN;
        ARMED: if (trig) state_d = RUN;
        RUN: begin
          pulse_d = win ^ pol;
          if (pre_q == div) begin
            pre_d = '0;
            if (count_q == period) begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = mode ? ARMED : RUN;
            end else begin
              count_d = count_q + 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      start_q <= '{default: '0};
      end_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  assign pulse      = pulse_q;
  assign busy       = (state_q == RUN);
  assign cycle_done = done_q;

endmodule
